// File: rtl/sram_rw_master.sv
// Drives one SRAM rw port and returns read data in order through a small FIFO; reads respond 2 cycles after fire.
// Requests stall (req_ready=0) once queued plus in-flight reads would fill the FIFO; writes stall by the same rule.
module sram_rw_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RESP_DEPTH = 3
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_dataIn,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_dataOut,
    output logic                  mem_enable,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    input  logic [DATA_WIDTH-1:0] mem_dataOut,
    output logic                  busy
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [CW-1:0]         occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] store_q [RESP_DEPTH];

    logic fire;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Counting the in-flight read reserves its FIFO slot a cycle ahead of the push.
    assign req_ready    = resetN && (({1'b0, occ_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(RESP_DEPTH));
    assign fire         = req_valid && req_ready;
    assign push         = inflight_q;
    assign pop          = resp_valid && resp_ready;

    assign mem_enable   = fire;
    assign mem_write    = fire && req_write;
    assign mem_addr     = req_addr;
    assign mem_dataIn   = req_dataIn;

    assign resp_valid   = (occ_q != '0);
    assign resp_dataOut = store_q[rd_ptr_q];
    assign busy         = inflight_q || (occ_q != '0);

    always_comb begin
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = fire && !req_write;
        if (push) begin
            wr_ptr_d = bump(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = bump(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push) begin
                store_q[wr_ptr_q] <= mem_dataOut;
            end
        end
    end

`ifndef SYNTHESIS
    push_never_on_full: assert property (@(posedge clock) disable iff (!resetN)
        !(push && !pop && (occ_q == CW'(RESP_DEPTH))));
`endif

endmodule

// File: tb/tb_sram_rw_master.sv
// Bench for sram_rw_master: table vectors, corner sequences and random traffic against an in-order response model.
module tb_sram_rw_master;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 3;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_dataIn = '0;
    logic          resp_ready = 1'b0;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_dataOut;
    logic          mem_enable;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dataIn;
    logic [DW-1:0] mem_dataOut = '0;
    logic          busy;

    sram_rw_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) dut (
        .clock(clock), .resetN(resetN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_dataIn(req_dataIn),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dataOut(resp_dataOut),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] pattern(input int a);
        return (DW'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural SRAM: unwritten words read back as pattern(addr), one-cycle read latency.
    logic [DW-1:0] sram    [1<<AW];
    bit            written [1<<AW];
    always @(posedge clock) begin
        if (mem_enable) begin
            if (mem_write) begin
                sram[mem_addr]    <= mem_dataIn;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_dataOut <= written[mem_addr] ? sram[mem_addr] : pattern(int'(mem_addr));
            end
        end
    end

    // Reference: every fired-but-unpopped read is one queue entry, visible from fire cycle + 2.
    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } rsp_t;
    rsp_t          rq [$];
    logic [DW-1:0] ref_mem [1<<AW];
    int            cyc = 0;

    int            errors = 0;
    int            checks = 0;
    int            dut_fires = 0;
    int            rv_cnt = 0;
    int            rv_rises = 0;
    bit            prev_rv = 1'b0;
    logic [DW-1:0] first_dat = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit w, input int a, input logic [DW-1:0] d, input bit rr);
        req_valid  = v;
        req_write  = w;
        req_addr   = AW'(a);
        req_dataIn = d;
        resp_ready = rr;
    endtask

    task automatic clear_counters();
        dut_fires = 0;
        rv_cnt    = 0;
        rv_rises  = 0;
        prev_rv   = 1'b0;
        first_dat = '0;
    endtask

    // Called shortly after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic cycle();
        bit   exp_rdy, exp_rv, fire, pop;
        rsp_t r;
        #2;
        exp_rdy = rq.size() < DEPTH;
        exp_rv  = (rq.size() > 0) && (rq[0].due <= cyc);
        check1("req_ready", req_ready, exp_rdy);
        check1("resp_valid", resp_valid, exp_rv);
        check1("busy", busy, rq.size() > 0);
        if (exp_rv) check("resp_dataOut", resp_dataOut, rq[0].d);
        fire = req_valid && exp_rdy;
        pop  = exp_rv && resp_ready;
        check1("mem_enable", mem_enable, fire);
        check1("mem_write", mem_write, fire && req_write);
        if (fire) check("mem_addr", DW'(mem_addr), DW'(req_addr));
        if (fire && req_write) check("mem_dataIn", mem_dataIn, req_dataIn);
        if (mem_enable) dut_fires++;
        if (resp_valid) begin
            rv_cnt++;
            if (!prev_rv) rv_rises++;
            if (rv_cnt == 1) first_dat = resp_dataOut;
        end
        prev_rv = resp_valid;
        @(posedge clock);
        if (pop) void'(rq.pop_front());
        if (fire) begin
            if (req_write) begin
                ref_mem[req_addr] = req_dataIn;
            end else begin
                r.d   = ref_mem[req_addr];
                r.due = cyc + 2;
                rq.push_back(r);
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    // Assert reset mid-cycle with a read presented, check outputs immediately, release on a falling edge.
    task automatic do_reset();
        drive(1, 0, 3, '0, 1);
        #1 resetN = 1'b0;
        #1;
        check1("rst req_ready", req_ready, 1'b0);
        check1("rst mem_enable", mem_enable, 1'b0);
        check1("rst mem_write", mem_write, 1'b0);
        check1("rst resp_valid", resp_valid, 1'b0);
        check1("rst busy", busy, 1'b0);
        check("rst resp_dataOut", resp_dataOut, '0);
        rq.delete();
        @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        drive(0, 0, 0, '0, 0);
    endtask

    typedef struct {
        bit            v, w;
        int            a;
        logic [DW-1:0] d;
        bit            rr;
        bit            e_rdy, e_rv, e_busy;
        logic [DW-1:0] e_dat;
    } vec_t;
    vec_t tbl [20];

    initial begin
        tbl[0]  = '{1, 1, 5, 32'hDEADBEEF, 1, 1, 0, 0, 32'h0};
        tbl[1]  = '{1, 0, 5, 32'h0,        1, 1, 0, 0, 32'h0};
        tbl[2]  = '{0, 0, 0, 32'h0,        0, 1, 0, 1, 32'h0};
        tbl[3]  = '{0, 0, 0, 32'h0,        0, 1, 1, 1, 32'hDEADBEEF};
        tbl[4]  = '{0, 0, 0, 32'h0,        1, 1, 1, 1, 32'hDEADBEEF};
        tbl[5]  = '{0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h0};
        tbl[6]  = '{1, 1, 1, 32'h11111111, 0, 1, 0, 0, 32'h0};
        tbl[7]  = '{1, 1, 2, 32'h22222222, 0, 1, 0, 0, 32'h0};
        tbl[8]  = '{1, 1, 3, 32'h33333333, 0, 1, 0, 0, 32'h0};
        tbl[9]  = '{1, 0, 1, 32'h0,        0, 1, 0, 0, 32'h0};
        tbl[10] = '{1, 0, 2, 32'h0,        0, 1, 0, 1, 32'h0};
        tbl[11] = '{1, 0, 3, 32'h0,        0, 1, 1, 1, 32'h11111111};
        tbl[12] = '{1, 0, 1, 32'h0,        0, 0, 1, 1, 32'h11111111};
        tbl[13] = '{1, 0, 1, 32'h0,        0, 0, 1, 1, 32'h11111111};
        tbl[14] = '{1, 1, 7, 32'h77777777, 1, 0, 1, 1, 32'h11111111};
        tbl[15] = '{1, 0, 1, 32'h0,        0, 1, 1, 1, 32'h22222222};
        tbl[16] = '{0, 0, 0, 32'h0,        1, 0, 1, 1, 32'h22222222};
        tbl[17] = '{0, 0, 0, 32'h0,        1, 1, 1, 1, 32'h33333333};
        tbl[18] = '{0, 0, 0, 32'h0,        1, 1, 1, 1, 32'h11111111};
        tbl[19] = '{0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h0};

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pattern(i);

        @(negedge clock);
        do_reset();
        for (int i = 0; i < 3; i++) cycle();

        // Write/read latency, backpressure to full, single-pop release.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rr);
            #1;
            check1($sformatf("tbl%0d req_ready", i), req_ready, tbl[i].e_rdy);
            check1($sformatf("tbl%0d resp_valid", i), resp_valid, tbl[i].e_rv);
            check1($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_rv) check($sformatf("tbl%0d resp_dataOut", i), resp_dataOut, tbl[i].e_dat);
            cycle();
        end

        // Back-to-back streaming reads of 0..15 with the consumer always ready.
        clear_counters();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, i, '0, 1);
            cycle();
        end
        checki("stream fires", dut_fires, 16);
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < 6; i++) cycle();
        checki("stream responses", rv_cnt, 16);
        checki("stream gap-free", rv_rises, 1);

        // Alternating consumer readiness across pointer wrap.
        clear_counters();
        for (int g = 0; g < 200 && dut_fires < 20; g++) begin
            drive(1, 0, (dut_fires * 5 + 3) % 32, '0, bit'(g % 2));
            cycle();
        end
        checki("wrap fires", dut_fires, 20);
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < 8; i++) cycle();

        // Reset while a read is in flight: only the post-reset read may respond.
        drive(1, 0, 3, '0, 1);
        cycle();
        do_reset();
        clear_counters();
        drive(1, 0, 7, '0, 1);
        cycle();
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < 6; i++) cycle();
        checki("midflight response count", rv_cnt, 1);
        check("midflight response data", first_dat, pattern(7));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) == 0, int'($urandom % 16), $urandom, ($urandom % 3) != 0);
            cycle();
        end
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < 8; i++) cycle();
        check1("drained busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_rw_master.md
SRAM_RW_MASTER -- requirements
Module: SramRwMaster

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 32, giving the SRAM word width in bits.
REQ-002 The block SHALL have the parameter ADDR_WIDTH, default 10, giving the SRAM address width in bits.
REQ-003 The block SHALL have the parameter RESP_DEPTH, default 3, giving the read-response FIFO entries; legal values are 2 or more.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clock  input  1  the single clock; all state changes on its rising edge.
- resetN  input  1  asynchronous active-low reset.
- req_valid  input  1  a request is presented.
- req_ready  output  1  the block accepts the request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_dataIn  input  DATA_WIDTH  write data.
- resp_valid  output  1  read data is available.
- resp_ready  input  1  the consumer takes the read data.
- resp_dataOut  output  DATA_WIDTH  read data, in request order.
- mem_enable  output  1  SRAM port enable.
- mem_write  output  1  SRAM port write strobe.
- mem_addr  output  ADDR_WIDTH  SRAM port address.
- mem_dataIn  output  DATA_WIDTH  SRAM port write data.
- mem_dataOut  input  DATA_WIDTH  SRAM port read data, valid one cycle after a read enable.
- busy  output  1  a read is in flight or the response FIFO is non-empty.

Function
REQ-005 The block SHALL drive one rw port of the team's single-port or dual-port SRAM wrapper.
REQ-006 The block SHALL treat a request as accepted (fire) in any cycle where req_valid=1 and req_ready=1.
REQ-007 The block SHALL compute req_ready = (occ + inflight < RESP_DEPTH) and resetN=1, where occ and inflight are register values only.
REQ-008 req_ready SHALL NOT depend on req_valid, req_write, resp_ready or resp_valid.
REQ-009 The block SHALL drive mem_enable = fire, combinationally.
REQ-010 The block SHALL drive mem_write = fire and req_write.
REQ-011 The block SHALL pass req_addr to mem_addr and req_dataIn to mem_dataIn every cycle.
REQ-012 The inflight flag SHALL be a 1-bit register, set at the end of a cycle that fires a read and cleared otherwise.
REQ-013 While inflight=1, the block SHALL push mem_dataOut into the response FIFO at the end of that cycle.
REQ-014 A write SHALL generate no response.
REQ-015 Writes SHALL be subject to the same req_ready rule as reads.
REQ-016 The response FIFO SHALL be first-in first-out, with occ counting 0..RESP_DEPTH.
REQ-017 The FIFO SHALL assert resp_valid = (occ != 0) and present the head entry on resp_dataOut.
REQ-018 The FIFO SHALL pop at the end of any cycle where resp_valid=1 and resp_ready=1.
REQ-019 On a simultaneous push and pop, occ SHALL stay unchanged and both operations SHALL happen.
REQ-020 A pop on an empty FIFO SHALL be impossible, because resp_valid=0.
REQ-021 A push to a full FIFO SHALL be impossible by construction of REQ-007; an assertion SHALL flag it.
REQ-022 The FIFO read and write pointers SHALL wrap modulo RESP_DEPTH, and RESP_DEPTH need not be a power of two.
REQ-023 Read latency SHALL be exactly 2 cycles: a read fired in cycle N gives resp_valid=1 in cycle N+2 if the FIFO was empty.
REQ-024 With RESP_DEPTH >= 3 and resp_ready held 1, the block SHALL sustain one read per cycle.
REQ-025 With RESP_DEPTH=2 and resp_ready held 1, the block SHALL sustain 2 reads per 3 cycles.
REQ-026 The block SHALL drive busy = inflight or (occ != 0).

Reset
REQ-027 While resetN=0, the block SHALL drive req_ready=0, mem_enable=0, mem_write=0, resp_valid=0, busy=0, occ=0, inflight=0 and both pointers=0.
REQ-028 While resetN=0, resp_dataOut SHALL be 0, with FIFO storage cleared.
REQ-029 If reset is asserted while a read is in flight, the block SHALL discard that read's data.
REQ-030 After resetN is released, the first response SHALL belong to the first read accepted after reset.
REQ-031 Reset SHALL assert asynchronously and SHALL be released synchronously to clock, with release synchronisation done outside the block.

Verification
REQ-032 Reset-then-idle: assert resetN=0 mid-cycle -> all outputs 0 immediately; after release with no requests -> req_ready=1, resp_valid=0, busy=0.
REQ-033 Write then read: write 0xDEADBEEF to addr 0x005, then read 0x005 with an SRAM model attached -> resp_dataOut=0xDEADBEEF with resp_valid first high 2 cycles after the read fire.
REQ-034 Streaming reads: RESP_DEPTH=3, resp_ready=1, read addrs 0..15 back-to-back -> 16 fires in 16 consecutive cycles and responses in order with no gaps.
REQ-035 Backpressure/full: resp_ready=0, issue reads -> exactly 3 fires, then req_ready=0 and occ=3; raise resp_ready for 1 cycle -> one pop, then req_ready=1 the next cycle.
REQ-036 Simultaneous push/pop and wrap: RESP_DEPTH=3, alternate resp_ready 1/0 over 20 reads -> data ordered correctly across pointer wrap, and no push-on-full assertion fires.
REQ-037 Reset mid-flight: fire a read of addr 0x3, assert resetN=0 in the next cycle, release, then read addr 0x7 -> exactly one response, carrying the data of 0x7.
